// File: rtl/ula_timing_pkg.sv
// Spectrum ULA beam timing constants shared by the beam counter and the
// contention/interrupt generator.
package ula_timing_pkg;

  localparam logic [8:0] H_LAST_48  = 9'd447;
  localparam logic [8:0] V_LAST_48  = 9'd311;
  localparam logic [8:0] H_LAST_128 = 9'd455;
  localparam logic [8:0] V_LAST_128 = 9'd310;

  localparam logic [8:0] WIN_PIXELS = 9'd256;
  localparam logic [8:0] WIN_LINES  = 9'd192;

  localparam logic [2:0] PH_FREE_A  = 3'd6;
  localparam logic [2:0] PH_FREE_B  = 3'd7;

  // True for the six T-states of an 8-T-state group in which the ULA fetches.
  function automatic logic phase_contends(input logic [2:0] ph);
    return (ph != PH_FREE_A) && (ph != PH_FREE_B);
  endfunction

endpackage

// File: rtl/ula_beam_counter.sv
// Local copy of the video beam position (hc/vc) with per-frame sampling of
// the 48K/128K timing select.
module ula_beam_counter
  import ula_timing_pkg::*;
#(
  parameter logic [8:0] V_END_48  = V_LAST_48,
  parameter logic [8:0] V_END_128 = V_LAST_128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic       timing_128k,
  output logic [8:0] hc,
  output logic [8:0] vc,
  output logic       mode_q,
  output logic       frame_start
);

  logic [8:0] h_last;
  logic [8:0] v_last;
  logic       h_wrap;
  logic       v_wrap;

  always_comb begin
    h_last      = mode_q ? H_LAST_128 : H_LAST_48;
    v_last      = mode_q ? V_END_128 : V_END_48;
    h_wrap      = (hc == h_last);
    v_wrap      = (vc == v_last);
    frame_start = pix_ce && h_wrap && v_wrap;
  end

  // Mode is only taken at the 0/0 wrap so a frame never mixes totals.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc     <= 9'd0;
      vc     <= 9'd0;
      mode_q <= 1'b0;
    end else if (pix_ce) begin
      if (h_wrap) begin
        hc <= 9'd0;
        vc <= v_wrap ? 9'd0 : vc + 9'd1;
      end else begin
        hc <= hc + 9'd1;
      end
      if (frame_start) begin
        mode_q <= timing_128k;
      end
    end
  end

endmodule

// File: rtl/ula_contention_gen.sv
// ULA contention request and frame interrupt generator for the CPU clock
// generator, driven from a local beam position copy.
module ula_contention_gen
  import ula_timing_pkg::*;
#(
  parameter logic [8:0] INT_LINE  = 9'd248,
  parameter int         INT_LEN   = 64,
  parameter logic [8:0] V_END_48  = V_LAST_48,
  parameter logic [8:0] V_END_128 = V_LAST_128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        timing_128k,
  input  logic        contention_en,
  input  logic [15:0] a,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic [2:0]  ram_bank,
  output logic        cpu_contention,
  output logic        int_n,
  output logic [8:0]  hc,
  output logic [8:0]  vc
);

  localparam logic [6:0] INT_LAST = 7'(INT_LEN - 1);

  logic       mode_q;
  logic       frame_start;
  logic       mem_slow;
  logic       io_slow;
  logic       window;
  logic       cont_next;
  logic       int_fire;
  logic       int_armed;
  logic [6:0] int_cnt;
  logic       unused_bits;

  ula_beam_counter #(
    .V_END_48   (V_END_48),
    .V_END_128  (V_END_128)
  ) u_beam (
    .clk         (clk),
    .rst         (rst),
    .pix_ce      (pix_ce),
    .timing_128k (timing_128k),
    .hc          (hc),
    .vc          (vc),
    .mode_q      (mode_q),
    .frame_start (frame_start)
  );

  assign unused_bits = ^{a[13:1], ram_bank[2:1]};

  // Odd 128K banks at C000h live in the contended RAM chips.
  always_comb begin
    mem_slow  = !mreq_n && ((a[15:14] == 2'b01) ||
                            ((a[15:14] == 2'b11) && mode_q && ram_bank[0]));
    io_slow   = !iorq_n && !a[0];
    window    = (vc < WIN_LINES) && (hc < WIN_PIXELS);
    cont_next = contention_en && window && phase_contends(hc[3:1]) &&
                (mem_slow || io_slow);
    int_fire  = int_armed && (vc == INT_LINE) && (hc == 9'd0);
  end

  // Contention follows every clk; the interrupt runs for INT_LEN pixel ticks
  // and is re-armed once per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_contention <= 1'b0;
      int_n          <= 1'b1;
      int_cnt        <= 7'd0;
      int_armed      <= 1'b1;
    end else begin
      cpu_contention <= cont_next;
      if (frame_start) begin
        int_armed <= 1'b1;
      end
      if (pix_ce) begin
        if (!int_n) begin
          if (int_cnt == INT_LAST) begin
            int_n   <= 1'b1;
            int_cnt <= 7'd0;
          end else begin
            int_cnt <= int_cnt + 7'd1;
          end
        end else if (int_fire) begin
          int_n     <= 1'b0;
          int_armed <= 1'b0;
        end
      end
    end
  end

endmodule
